// File: rtl/chorus_mod_ctrl.sv
// Chorus/delay modulation and enable sequencer: triangle-modulated delay time
// between run-time bounds, plus a per-sample wet-level fade for enable/disable.
module chorus_mod_ctrl #(
  parameter int TWIDTH = 11,
  parameter int RWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              sample_tick_i,
  input  logic              enable_i,
  input  logic [7:0]        level_i,
  input  logic [RWIDTH-1:0] rate_i,
  input  logic [TWIDTH-1:0] min_time_i,
  input  logic [TWIDTH-1:0] max_time_i,
  output logic [TWIDTH-1:0] time_o,
  output logic [7:0]        level_o,
  output logic              bypass_o,
  output logic              dir_o
);

  typedef enum logic [1:0] {
    ST_BYPASS   = 2'd0,
    ST_FADE_IN  = 2'd1,
    ST_RUN      = 2'd2,
    ST_FADE_OUT = 2'd3
  } state_e;

  localparam logic [TWIDTH-1:0] TIME_MAX = {TWIDTH{1'b1}};
  localparam logic [TWIDTH-1:0] TIME_ONE = TWIDTH'(1);
  localparam logic [RWIDTH-1:0] CNT_ONE  = RWIDTH'(1);

  state_e             state_q, state_d;
  logic [RWIDTH-1:0]  cnt_q, cnt_d;
  logic [TWIDTH-1:0]  time_q, time_d;
  logic [7:0]         level_q, level_d;
  logic               bypass_q, bypass_d;
  logic               dir_q, dir_d;
  logic               step_en_s;
  logic [TWIDTH-1:0]  time_inc_s;
  logic [TWIDTH-1:0]  time_dec_s;

  // Rate divider: a time step is due when the counter matches rate_i.
  always_comb begin
    step_en_s = (cnt_q == rate_i);
    cnt_d     = cnt_q;
    if (sample_tick_i) begin
      if (step_en_s) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Enable sequencer; an enable edge wins over a fade completing in the same clk.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BYPASS: begin
        if (enable_i) begin
          state_d = ST_FADE_IN;
        end else begin
          state_d = ST_BYPASS;
        end
      end
      ST_FADE_IN: begin
        if (!enable_i) begin
          state_d = ST_FADE_OUT;
        end else if (level_q == level_i) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FADE_IN;
        end
      end
      ST_RUN: begin
        if (!enable_i) begin
          state_d = ST_FADE_OUT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FADE_OUT: begin
        if (enable_i) begin
          state_d = ST_FADE_IN;
        end else if (level_q == 8'd0) begin
          state_d = ST_BYPASS;
        end else begin
          state_d = ST_FADE_OUT;
        end
      end
      default: begin
        state_d = ST_BYPASS;
      end
    endcase
    bypass_d = (state_d == ST_BYPASS);
  end

  // Wet level slews one LSB per sample toward its target.
  always_comb begin
    level_d = level_q;
    if (state_q == ST_BYPASS) begin
      level_d = 8'd0;
    end else if (sample_tick_i) begin
      if (state_q == ST_FADE_OUT) begin
        if (level_q != 8'd0) begin
          level_d = level_q - 8'd1;
        end else begin
          level_d = level_q;
        end
      end else if (level_q < level_i) begin
        level_d = level_q + 8'd1;
      end else if (level_q > level_i) begin
        level_d = level_q - 8'd1;
      end else begin
        level_d = level_q;
      end
    end else begin
      level_d = level_q;
    end
  end

  // Saturating neighbours so the time bus can never wrap.
  always_comb begin
    time_inc_s = (time_q == TIME_MAX) ? time_q : (time_q + TIME_ONE);
    time_dec_s = (time_q == '0) ? time_q : (time_q - TIME_ONE);
  end

  // Triangle modulation; bound clamps take priority over stepping.
  always_comb begin
    time_d = time_q;
    dir_d  = dir_q;
    if (state_q == ST_BYPASS) begin
      time_d = min_time_i;
      dir_d  = 1'b1;
    end else if (sample_tick_i) begin
      if (min_time_i >= max_time_i) begin
        time_d = min_time_i;
      end else if (time_q > max_time_i) begin
        time_d = max_time_i;
        dir_d  = 1'b0;
      end else if (time_q < min_time_i) begin
        time_d = min_time_i;
        dir_d  = 1'b1;
      end else if (step_en_s) begin
        if (dir_q) begin
          time_d = time_inc_s;
          dir_d  = (time_inc_s >= max_time_i) ? 1'b0 : 1'b1;
        end else begin
          time_d = time_dec_s;
          dir_d  = (time_dec_s <= min_time_i) ? 1'b1 : 1'b0;
        end
      end else begin
        time_d = time_q;
      end
    end else begin
      time_d = time_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_BYPASS;
      cnt_q    <= '0;
      time_q   <= '0;
      level_q  <= 8'd0;
      bypass_q <= 1'b1;
      dir_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      time_q   <= time_d;
      level_q  <= level_d;
      bypass_q <= bypass_d;
      dir_q    <= dir_d;
    end
  end

  assign time_o   = time_q;
  assign level_o  = level_q;
  assign bypass_o = bypass_q;
  assign dir_o    = dir_q;

endmodule
